// File: rtl/urv_writeback_pkg.sv
// Shared constants for the uRV writeback stage: load funct3 codes and FSM states.
package urv_writeback_pkg;

  localparam logic [2:0] FUN_LB  = 3'b000;
  localparam logic [2:0] FUN_LH  = 3'b001;
  localparam logic [2:0] FUN_LW  = 3'b010;
  localparam logic [2:0] FUN_LBU = 3'b100;
  localparam logic [2:0] FUN_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_IDLE      = 2'd0,
    WB_RESULT    = 2'd1,
    WB_LOAD_WAIT = 2'd2
  } wb_state_t;

endpackage

// File: rtl/urv_writeback_load_align.sv
// Load data alignment: picks the addressed byte/half out of the memory word and extends it.
module urv_load_align
  import urv_writeback_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  fun,
  input  logic [1:0]  addr,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    // addr[0] is don't-care for halves; misaligned accesses never reach here
    half_sel = addr[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    data = raw;
    case (fun)
      FUN_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      FUN_LBU: data = {24'h0, byte_sel};
      FUN_LH:  data = {{16{half_sel[15]}}, half_sel};
      FUN_LHU: data = {16'h0, half_sel};
      FUN_LW:  data = raw;
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/urv_writeback.sv
// uRV writeback stage: registers execute results, waits on loads, drives RF write/bypass.
// Optional retired-instruction counter enabled by defining KMKZ_WB_INSTRET_EN.
module urv_writeback
  import urv_writeback_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic        x_load_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic        w_stall_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_store_o,
  output logic        rf_bypass_rd_write_o,
  output logic [31:0] rf_bypass_rd_value_o
`ifdef KMKZ_WB_INSTRET_EN
  ,
  output logic [63:0] w_instret_o
`endif
);

  wb_state_t   state, state_nxt;
  logic [4:0]  rd_q;
  logic [31:0] value_q;
  logic        write_q;
  logic [2:0]  fun_q;
  logic [1:0]  addr_q;
  logic        capture;
  logic [31:0] load_data;

  urv_load_align u_align (
    .raw  (dm_data_l_i),
    .fun  (fun_q),
    .addr (addr_q),
    .data (load_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= WB_IDLE;
      rd_q    <= '0;
      value_q <= '0;
      write_q <= 1'b0;
      fun_q   <= '0;
      addr_q  <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        rd_q    <= x_rd_i;
        value_q <= x_rd_value_i;
        write_q <= x_rd_write_i;
        fun_q   <= x_fun_i;
        addr_q  <= x_dm_addr_i;
      end
    end
  end

  always_comb begin
    w_stall_o     = 1'b0;
    rf_rd_store_o = 1'b0;
    rf_rd_value_o = value_q;
    state_nxt     = WB_IDLE;
    case (state)
      WB_RESULT: rf_rd_store_o = write_q && (rd_q != 5'd0);
      WB_LOAD_WAIT: begin
        w_stall_o     = !dm_load_done_i;
        rf_rd_store_o = dm_load_done_i && write_q && (rd_q != 5'd0);
        rf_rd_value_o = load_data;
      end
      default: ;
    endcase
    capture = x_valid_i && !w_stall_o;
    // An outstanding load holds the stage until its data returns
    if (w_stall_o)    state_nxt = WB_LOAD_WAIT;
    else if (capture) state_nxt = x_load_i ? WB_LOAD_WAIT : WB_RESULT;
  end

  assign rf_rd_o              = rd_q;
  assign rf_bypass_rd_write_o = rf_rd_store_o;
  assign rf_bypass_rd_value_o = rf_rd_value_o;

`ifdef KMKZ_WB_INSTRET_EN
  logic retire;
  assign retire = (state == WB_RESULT) || ((state == WB_LOAD_WAIT) && dm_load_done_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      w_instret_o <= '0;
    else if (retire) w_instret_o <= w_instret_o + 64'd1;
  end
`endif

endmodule

// File: tb/tb_urv_writeback.sv
// Directed bench for urv_writeback: pending-instruction model checked every cycle plus literal checks.
module tb_urv_writeback;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        x_valid_i = 1'b0;
  logic [4:0]  x_rd_i = '0;
  logic [31:0] x_rd_value_i = '0;
  logic        x_rd_write_i = 1'b0;
  logic        x_load_i = 1'b0;
  logic [2:0]  x_fun_i = '0;
  logic [1:0]  x_dm_addr_i = '0;
  logic [31:0] dm_data_l_i = '0;
  logic        dm_load_done_i = 1'b0;
  logic        w_stall_o, rf_rd_store_o, rf_bypass_rd_write_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o, rf_bypass_rd_value_o;
`ifdef KMKZ_WB_INSTRET_EN
  logic [63:0] w_instret_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  urv_writeback dut (
    .clk_i(clk), .rst_i(rst_i), .x_valid_i(x_valid_i), .x_rd_i(x_rd_i),
    .x_rd_value_i(x_rd_value_i), .x_rd_write_i(x_rd_write_i), .x_load_i(x_load_i),
    .x_fun_i(x_fun_i), .x_dm_addr_i(x_dm_addr_i), .dm_data_l_i(dm_data_l_i),
    .dm_load_done_i(dm_load_done_i), .w_stall_o(w_stall_o), .rf_rd_o(rf_rd_o),
    .rf_rd_value_o(rf_rd_value_o), .rf_rd_store_o(rf_rd_store_o),
    .rf_bypass_rd_write_o(rf_bypass_rd_write_o), .rf_bypass_rd_value_o(rf_bypass_rd_value_o)
`ifdef KMKZ_WB_INSTRET_EN
    , .w_instret_o(w_instret_o)
`endif
  );

  // ---------------- model: one pending instruction record ----------------
  int          m_kind;   // 0 nothing, 1 plain result, 2 load outstanding
  logic [4:0]  m_rd;
  logic [31:0] m_val;
  logic        m_wr;
  logic [2:0]  m_fun;
  logic [1:0]  m_addr;
  logic [63:0] m_retired;

  function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [2:0] f,
                                            input logic [1:0] a);
    logic [31:0] sb, sh;
    sb = w >> (8 * a);
    sh = w >> (16 * a[1]);
    case (f)
      3'b000:  return 32'($signed(sb[7:0]));
      3'b100:  return 32'(sb[7:0]);
      3'b001:  return 32'($signed(sh[15:0]));
      3'b101:  return 32'(sh[15:0]);
      default: return w;
    endcase
  endfunction

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_kind <= 0; m_rd <= '0; m_val <= '0; m_wr <= 1'b0; m_fun <= '0; m_addr <= '0;
      m_retired <= '0;
    end else begin
      if (m_kind == 1 || (m_kind == 2 && dm_load_done_i)) m_retired <= m_retired + 64'd1;
      if (m_kind == 2 && !dm_load_done_i) begin
        m_kind <= 2;
      end else if (x_valid_i) begin
        m_kind <= x_load_i ? 2 : 1;
        m_rd <= x_rd_i; m_val <= x_rd_value_i; m_wr <= x_rd_write_i;
        m_fun <= x_fun_i; m_addr <= x_dm_addr_i;
      end else begin
        m_kind <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic        e_store, e_stall;
    logic [31:0] e_val;
    if (rst_i) begin
      e_stall = (m_kind == 2) && !dm_load_done_i;
      e_store = ((m_kind == 1) || (m_kind == 2 && dm_load_done_i)) && m_wr && (m_rd != 5'd0);
      e_val   = (m_kind == 2) ? ref_align(dm_data_l_i, m_fun, m_addr) : m_val;
      chk("model_stall", 64'(w_stall_o), 64'(e_stall));
      chk("model_store", 64'(rf_rd_store_o), 64'(e_store));
      chk("model_rd", 64'(rf_rd_o), 64'(m_rd));
      if (e_store) chk("model_value", 64'(rf_rd_value_o), 64'(e_val));
      chk("bypass_write", 64'(rf_bypass_rd_write_o), 64'(rf_rd_store_o));
      chk("bypass_value", 64'(rf_bypass_rd_value_o), 64'(rf_rd_value_o));
`ifdef KMKZ_WB_INSTRET_EN
      chk("model_instret", w_instret_o, m_retired);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] rd, input logic [31:0] val,
                     input logic wr, input logic ld, input logic [2:0] f, input logic [1:0] a);
    x_valid_i = v; x_rd_i = rd; x_rd_value_i = val; x_rd_write_i = wr;
    x_load_i = ld; x_fun_i = f; x_dm_addr_i = a;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0);
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  // capture a load, hold it two stall cycles, then return data; check the written value
  task automatic do_load(input string name, input logic [4:0] rd, input logic [2:0] f,
                         input logic [1:0] a, input logic [31:0] data, input logic [31:0] exp);
    step(); drv(1'b1, rd, 32'h0, 1'b1, 1'b1, f, a);
    step(); idle();
    mid(); chk({name, "_stall1"}, 64'(w_stall_o), 64'd1);
    step(); mid(); chk({name, "_stall2"}, 64'(w_stall_o), 64'd1);
    step(); dm_data_l_i = data; dm_load_done_i = 1'b1; #1;
    chk({name, "_store"}, 64'(rf_rd_store_o), 64'(rd != 5'd0));
    chk({name, "_value"}, 64'(rf_rd_value_o), 64'(exp));
    chk({name, "_nostall"}, 64'(w_stall_o), 64'd0);
    step(); dm_load_done_i = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_store", 64'(rf_rd_store_o), 64'd0);
    chk("rst_stall", 64'(w_stall_o), 64'd0);
    chk("rst_rd", 64'(rf_rd_o), 64'd0);
    chk("rst_value", 64'(rf_rd_value_o), 64'd0);
    chk("rst_bypass", 64'(rf_bypass_rd_write_o), 64'd0);
    #9 rst_i = 1'b1;

    step(); drv(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 3'd0, 2'd0);
    step(); idle();
    mid();
    chk("res_store", 64'(rf_rd_store_o), 64'd1);
    chk("res_rd", 64'(rf_rd_o), 64'd5);
    chk("res_value", 64'(rf_rd_value_o), 64'hDEADBEEF);
    chk("res_bypass", 64'(rf_bypass_rd_value_o), 64'hDEADBEEF);

    step(); drv(1'b1, 5'd0, 32'h123, 1'b1, 1'b0, 3'd0, 2'd0);
    step(); idle();
    mid(); chk("x0_nostore", 64'(rf_rd_store_o), 64'd0);

    do_load("lb",   5'd3,  3'b000, 2'b11, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lhu",  5'd8,  3'b101, 2'b10, 32'h8001_1234, 32'h0000_8001);
    do_load("lw",   5'd9,  3'b010, 2'b00, 32'h8001_1234, 32'h8001_1234);
    do_load("lh",   5'd10, 3'b001, 2'b01, 32'h0000_F234, 32'hFFFF_F234);
    do_load("lbu",  5'd11, 3'b100, 2'b01, 32'h0000_8000, 32'h0000_0080);
    do_load("undef",5'd12, 3'b011, 2'b10, 32'h1357_9BDF, 32'h1357_9BDF);
    do_load("ldx0", 5'd0,  3'b010, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // load completes in the same cycle a non-load is presented
    step(); drv(1'b1, 5'd9, 32'h0, 1'b1, 1'b1, 3'b010, 2'b00);
    step(); drv(1'b1, 5'd7, 32'h1, 1'b1, 1'b0, 3'd0, 2'd0);
    dm_data_l_i = 32'hCAFE_F00D; dm_load_done_i = 1'b1; #1;
    chk("ovl_ld_store", 64'(rf_rd_store_o), 64'd1);
    chk("ovl_ld_rd", 64'(rf_rd_o), 64'd9);
    chk("ovl_ld_value", 64'(rf_rd_value_o), 64'hCAFE_F00D);
    chk("ovl_ld_stall", 64'(w_stall_o), 64'd0);
    step(); idle(); dm_load_done_i = 1'b0; #1;
    chk("ovl_nl_store", 64'(rf_rd_store_o), 64'd1);
    chk("ovl_nl_rd", 64'(rf_rd_o), 64'd7);
    chk("ovl_nl_value", 64'(rf_rd_value_o), 64'h1);

    // reset in the middle of an outstanding load
    step(); drv(1'b1, 5'd4, 32'h0, 1'b1, 1'b1, 3'b010, 2'b00);
    step(); idle();
    chk("abort_pre_stall", 64'(w_stall_o), 64'd1);
    rst_i = 1'b0; #1;
    chk("abort_stall", 64'(w_stall_o), 64'd0);
    chk("abort_store", 64'(rf_rd_store_o), 64'd0);
    #1 rst_i = 1'b1;
    step(); dm_data_l_i = 32'hFFFF_FFFF; dm_load_done_i = 1'b1; #1;
    chk("stray_done", 64'(rf_rd_store_o), 64'd0);
    step(); dm_load_done_i = 1'b0;

`ifdef KMKZ_WB_INSTRET_EN
    rst_i = 1'b0; #1;
    chk("instret_rst", w_instret_o, 64'd0);
    #1 rst_i = 1'b1;
    step(); drv(1'b1, 5'd1, 32'h11, 1'b1, 1'b0, 3'd0, 2'd0);
    step(); drv(1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 3'd0, 2'd0);
    step(); drv(1'b1, 5'd0, 32'h33, 1'b1, 1'b0, 3'd0, 2'd0);
    step(); drv(1'b1, 5'd6, 32'h0, 1'b1, 1'b1, 3'b010, 2'b00);
    step(); idle();
    step(); dm_data_l_i = 32'h44; dm_load_done_i = 1'b1;
    step(); dm_load_done_i = 1'b0; #1;
    chk("instret_4", w_instret_o, 64'd4);
`endif

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
